gerador_quadro_rolagem: RTL and testbench

//  Frame generator that feeds the 5x7 LED matrix scan stage.

---
 rtl/gerador_quadro_rolagem.sv | 129 ++++++++++++
 tb/tb_gerador_quadro_rolagem.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gerador_quadro_rolagem.sv
// gerador_quadro_rolagem: frame generator for the 5x7 LED matrix scan stage.
// Renders a 4-digit BCD message with a 3x5 font into a scroll strip and shows a
// 7-column window of it as static, scrolling or blinking, selected by {ch1,ch0}.
// Ports:
//   CLK    - system clock, rising edge
//   RST_N  - asynchronous active-low reset
//   ch0    - mode select LSB
//   ch1    - mode select MSB (00 off, 01 static, 10 scroll, 11 blink)
//   digits - BCD message, [15:12] is the leftmost digit
//   load   - one-cycle strobe that captures digits
//   frame  - pixel levels, bit (c-1)*5+(l-1) = column Cc line Ll, 0 = lit
//   tick   - one-cycle animation tick pulse
//   offset - current scroll start column
module gerador_quadro_rolagem #(
    parameter int TICK_DIV    = 12_500_000,
    parameter int BLINK_TICKS = 2,
    parameter int GAP_COLS    = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ch0,
    input  logic        ch1,
    input  logic [15:0] digits,
    input  logic        load,
    output logic [34:0] frame,
    output logic        tick,
    output logic [4:0]  offset
);
    localparam int STRIP_LEN = 16 + GAP_COLS;
    localparam int DW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [1:0] OFF    = 2'b00;
    localparam logic [1:0] STATIC = 2'b01;
    localparam logic [1:0] SCROLL = 2'b10;
    localparam logic [1:0] BLINK  = 2'b11;

    logic [DW-1:0] div_cnt;
    logic [1:0]    mode;
    logic [1:0]    mode_next;
    logic [15:0]   dig;
    logic          hidden;
    logic [BW-1:0] blink_cnt;
    logic [34:0]   frame_next;
    logic [5:0]    idx;

    // Glyph packed as {col2, col1, col0}; bit 0 of each column is the top line.
    function automatic logic [14:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = {5'b11111, 5'b10001, 5'b11111};
            4'd1:    glyph = {5'b00000, 5'b11111, 5'b00000};
            4'd2:    glyph = {5'b10111, 5'b10101, 5'b11101};
            4'd3:    glyph = {5'b11111, 5'b10101, 5'b10101};
            4'd4:    glyph = {5'b11111, 5'b00100, 5'b00111};
            4'd5:    glyph = {5'b11101, 5'b10101, 5'b10111};
            4'd6:    glyph = {5'b11101, 5'b10101, 5'b11111};
            4'd7:    glyph = {5'b11111, 5'b00001, 5'b00001};
            4'd8:    glyph = {5'b11111, 5'b10101, 5'b11111};
            4'd9:    glyph = {5'b11111, 5'b10101, 5'b10111};
            default: glyph = 15'd0;
        endcase
    endfunction

    // Lit pattern of strip column s: digit s/4, glyph column s%4; spacer and gap are blank.
    // The nibble for digit i sits at bit 4*(3-i), which is {~i,2'b00} for a 2-bit i.
    function automatic logic [4:0] strip_col(input logic [15:0] dg, input logic [5:0] s);
        logic [3:0]  d;
        logic [14:0] g;
        d = 4'(dg >> {~s[3:2], 2'b00});
        g = glyph(d);
        strip_col = (s >= 6'd16 || s[1:0] == 2'd3) ? 5'd0 : 5'(g >> (5 * s[1:0]));
    endfunction

    assign mode_next = {ch1, ch0};
    assign tick      = (div_cnt == DW'(TICK_DIV - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) div_cnt <= '0;
        else        div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)    dig <= '0;
        else if (load) dig <= digits;
    end

    // A mode change restarts the animation, taking priority over a coincident tick.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode      <= OFF;
            offset    <= '0;
            hidden    <= 1'b0;
            blink_cnt <= '0;
        end else begin
            mode <= mode_next;
            if (mode_next != mode) begin
                offset    <= '0;
                hidden    <= 1'b0;
                blink_cnt <= '0;
            end else if (mode == SCROLL && tick) begin
                offset <= (offset == 5'(STRIP_LEN - 1)) ? '0 : offset + 5'd1;
            end else if (mode == BLINK && tick) begin
                if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                    blink_cnt <= '0;
                    hidden    <= ~hidden;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // offset < STRIP_LEN and k <= 6 < 16 <= STRIP_LEN, so one subtraction wraps.
    always_comb begin
        frame_next = '1;
        idx        = '0;
        if (mode != OFF && !(mode == BLINK && hidden)) begin
            for (int k = 0; k < 7; k++) begin
                idx = {1'b0, offset} + 6'(k);
                if (idx >= 6'(STRIP_LEN)) idx = idx - 6'(STRIP_LEN);
                frame_next[k*5 +: 5] = ~strip_col(dig, idx);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) frame <= '1;
        else        frame <= frame_next;
    end
endmodule

// File: tb/tb_gerador_quadro_rolagem.sv
// tb_gerador_quadro_rolagem: scoreboard bench for gerador_quadro_rolagem with a behavioural model.
module tb_gerador_quadro_rolagem;
    localparam int TD  = 4;
    localparam int BT  = 2;
    localparam int GAP = 3;
    localparam int SL  = 16 + GAP;
    localparam logic [34:0] S2 = 35'b00000_01110_00000_11111_11111_00000_11111;
    // Font rows top to bottom, each row 3 bits with the left column as MSB.
    localparam logic [14:0] FONT [10] = '{
        15'b111_101_101_101_111, 15'b010_010_010_010_010, 15'b111_001_111_100_111,
        15'b111_001_111_001_111, 15'b101_101_111_001_001, 15'b111_100_111_001_111,
        15'b111_100_111_101_111, 15'b111_001_001_001_001, 15'b111_101_111_101_111,
        15'b111_101_111_001_111};

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        ch0 = 1'b0;
    logic        ch1 = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits = '0;
    logic [34:0] frame;
    logic        tick;
    logic [4:0]  offset;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [34:0] f;
        logic        t;
        logic [4:0]  o;
    } exp_t;
    exp_t sbq[$];

    gerador_quadro_rolagem #(.TICK_DIV(TD), .BLINK_TICKS(BT), .GAP_COLS(GAP)) dut (
        .CLK(CLK), .RST_N(RST_N), .ch0(ch0), .ch1(ch1), .digits(digits),
        .load(load), .frame(frame), .tick(tick), .offset(offset));

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    function automatic logic [4:0] lit_col(input logic [15:0] dg, input int s);
        logic [3:0] d;
        logic [4:0] c;
        c = '0;
        if (s >= 16 || s % 4 == 3) return c;
        d = dg[15-4*(s/4) -: 4];
        if (d > 9) return c;
        for (int r = 0; r < 5; r++) c[r] = FONT[d][14 - 3*r - (s % 4)];
        return c;
    endfunction

    function automatic logic [34:0] render(input int md, input logic [15:0] dg, input int off, input bit hid);
        logic [34:0] f;
        f = '1;
        if (md == 0 || (md == 3 && hid)) return f;
        for (int k = 0; k < 7; k++) f[k*5 +: 5] = ~lit_col(dg, (off + k) % SL);
        return f;
    endfunction

    // Reference model: state after each edge, expected outputs pushed to the scoreboard.
    int          m_mode = 0;
    int          m_off = 0;
    int          m_div = 0;
    int          m_bt = 0;
    bit          m_hid = 0;
    logic [15:0] m_dig = '0;
    exp_t        e_m;
    bit          t_m;
    int          nm_m;

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_mode = 0; m_off = 0; m_div = 0; m_bt = 0; m_hid = 0; m_dig = '0;
            e_m.f = '1; e_m.t = 1'b0; e_m.o = '0;
        end else begin
            t_m = (m_div == TD - 1);
            e_m.f = render(m_mode, m_dig, m_off, m_hid);
            nm_m = {ch1, ch0};
            if (load) m_dig = digits;
            if (nm_m != m_mode) begin
                m_mode = nm_m; m_off = 0; m_hid = 0; m_bt = 0;
            end else if (m_mode == 2 && t_m) begin
                m_off = (m_off + 1) % SL;
            end else if (m_mode == 3 && t_m) begin
                m_bt++;
                if (m_bt == BT) begin
                    m_bt = 0;
                    m_hid = !m_hid;
                end
            end
            m_div = t_m ? 0 : m_div + 1;
            e_m.t = (m_div == TD - 1);
            e_m.o = 5'(m_off);
        end
        sbq.push_back(e_m);
    end

    exp_t e_c;
    always @(negedge CLK) begin
        if (sbq.size() > 0) begin
            e_c = sbq.pop_front();
            chk("sb_frame", frame, e_c.f);
            chk("sb_tick", 35'(tick), 35'(e_c.t));
            chk("sb_offset", 35'(offset), 35'(e_c.o));
        end
    end

    task automatic step();
        @(negedge CLK);
    endtask

    // Returns at the negedge just after the edge that consumed the next tick.
    task automatic wait_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (tick !== 1'b1) timeout("wait_tick");
        step();
    endtask

    task automatic set_ch(input logic [1:0] c);
        {ch1, ch0} = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int off0;
        int n;
        #1 RST_N = 1'b0;
        digits = 16'h1000;
        repeat (3) step();
        chk("reset_frame", frame, '1);
        chk("reset_offset", 35'(offset), 35'd0);
        chk("reset_tick", 35'(tick), 35'd0);
        RST_N = 1'b1;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (12) step();
        chk("off_mode_blank", frame, '1);
        // static
        set_ch(2'b01);
        step();
        chk("static_latency1", frame, '1);
        step();
        chk("static_frame", frame, S2);
        // scroll, synchronised to a tick so none is lost to the mode change
        wait_tick();
        set_ch(2'b10);
        step();
        wait_tick();
        chk("scroll_off1", 35'(offset), 35'd1);
        step();
        chk("scroll_c1", 35'(frame[4:0]), 35'd0);
        for (int i = 0; i < 18; i++) wait_tick();
        chk("scroll_wrap_off", 35'(offset), 35'd0);
        step();
        chk("scroll_wrap_frame", frame, S2);
        // blink
        wait_tick();
        set_ch(2'b11);
        step();
        step();
        chk("blink_visible", frame, S2);
        wait_tick();
        wait_tick();
        step();
        chk("blink_hidden", frame, '1);
        wait_tick();
        wait_tick();
        step();
        chk("blink_visible2", frame, S2);
        wait_tick();
        wait_tick();
        step();
        chk("blink_hidden2", frame, '1);
        set_ch(2'b01);
        step();
        step();
        chk("blink_to_static", frame, S2);
        // load in static with BCD A blanking digit 1
        digits = 16'h1A00;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk("load_blank_c5c7", 35'(frame[34:20]), 35'h7FFF);
        chk("load_keep_c1c4", 35'(frame[19:0]), 35'(S2[19:0]));
        // load coincident with a scroll tick
        wait_tick();
        set_ch(2'b10);
        step();
        n = 0;
        while (tick !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (tick !== 1'b1) timeout("coincident_tick");
        off0 = offset;
        digits = 16'h2345;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("coinc_offset", 35'(offset), 35'((off0 + 1) % SL));
        step();
        chk("coinc_frame", frame, render(2, 16'h2345, (off0 + 1) % SL, 0));
        // async reset mid-scroll at offset 7
        n = 0;
        while (offset !== 5'd7 && n < 200) begin
            step();
            n++;
        end
        if (offset !== 5'd7) timeout("reach_offset7");
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst_frame", frame, '1);
        chk("async_rst_offset", 35'(offset), 35'd0);
        chk("async_rst_tick", 35'(tick), 35'd0);
        repeat (3) step();
        RST_N = 1'b1;
        step();
        step();
        chk("post_rst_no_tick", 35'(tick), 35'd0);
        step();
        chk("post_rst_first_tick", 35'(tick), 35'd1);
        // randomized phase, checked by the scoreboard
        for (int i = 0; i < 600; i++) begin
            step();
            if ($urandom_range(0, 19) == 0) set_ch(2'($urandom_range(0, 3)));
            load = ($urandom_range(0, 7) == 0);
            if (load) digits = 16'($urandom);
        end
        load = 1'b0;
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
